// File: rtl/sopc_mem_bridge.sv
// Shares one combinational-read memory between the CPU fetch and data ports.
// Arbitrates the ports, inserts WAIT_STATES extra cycles and returns per-port stalls.
module sopc_mem_bridge #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int WAIT_STATES   = 1,
  parameter int DATA_PRIORITY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rom_ce_i,
  input  logic [ADDR_W-1:0]   rom_addr_i,
  output logic [DATA_W-1:0]   rom_data_o,
  output logic                inst_stall_o,
  input  logic                ram_ce_i,
  input  logic                ram_we_i,
  input  logic [ADDR_W-1:0]   ram_addr_i,
  input  logic [DATA_W/8-1:0] ram_sel_i,
  input  logic [DATA_W-1:0]   ram_data_i,
  output logic [DATA_W-1:0]   ram_data_o,
  output logic                data_stall_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [DATA_W-1:0]   mem_data_o,
  input  logic [DATA_W-1:0]   mem_data_i
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [3:0]          cnt_r;
  logic                grant_r;       // 1 = data port owns the current access
  logic                last_grant_r;  // 1 = data port was granted last
  logic [ADDR_W-1:0]   addr_r;
  logic                we_r;
  logic [SEL_W-1:0]    sel_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [DATA_W-1:0]   rom_data_r;
  logic [DATA_W-1:0]   ram_data_r;
  logic                load_s;
  logic                pick_data_s;
  logic                done_s;
  logic                busy_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Arbitration, next state and completion detect
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    pick_data_s = 1'b0;
    done_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (rom_ce_i || ram_ce_i) begin
          load_s      = 1'b1;
          state_nxt_s = BUSY;
          if (rom_ce_i && ram_ce_i) begin
            // round-robin hands a tie to whichever port did not go last
            pick_data_s = (DATA_PRIORITY != 0) ? 1'b1 : ~last_grant_r;
          end else begin
            pick_data_s = ram_ce_i;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BUSY: begin
        if (cnt_r == 4'd0) begin
          done_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request latch, wait-state counter and read-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r        <= 4'd0;
      grant_r      <= 1'b0;
      last_grant_r <= 1'b0;
      addr_r       <= '0;
      we_r         <= 1'b0;
      sel_r        <= '0;
      wdata_r      <= '0;
      rom_data_r   <= '0;
      ram_data_r   <= '0;
    end else begin
      if (load_s) begin
        grant_r      <= pick_data_s;
        last_grant_r <= pick_data_s;
        cnt_r        <= 4'(WAIT_STATES);
        if (pick_data_s) begin
          addr_r  <= ram_addr_i;
          we_r    <= ram_we_i;
          sel_r   <= ram_sel_i;
          wdata_r <= ram_data_i;
        end else begin
          addr_r  <= rom_addr_i;
          we_r    <= 1'b0;
          sel_r   <= '1;
          wdata_r <= '0;
        end
      end else if (state_r == BUSY && cnt_r != 4'd0) begin
        cnt_r <= cnt_r - 4'd1;
      end
      // captured even if the requester already dropped ce
      if (done_s && !we_r) begin
        if (grant_r) begin
          ram_data_r <= mem_data_i;
        end else begin
          rom_data_r <= mem_data_i;
        end
      end
    end
  end

  assign busy_s     = (state_r == BUSY);
  assign mem_ce_o   = busy_s;
  assign mem_we_o   = busy_s & we_r;
  assign mem_addr_o = busy_s ? addr_r  : '0;
  assign mem_sel_o  = busy_s ? sel_r   : '0;
  assign mem_data_o = busy_s ? wdata_r : '0;

  // Read data bypasses the register on the completion cycle so the pipeline sees it immediately
  assign rom_data_o   = (done_s && !grant_r && !we_r) ? mem_data_i : rom_data_r;
  assign ram_data_o   = (done_s &&  grant_r && !we_r) ? mem_data_i : ram_data_r;
  assign inst_stall_o = rom_ce_i & ~(done_s & ~grant_r);
  assign data_stall_o = ram_ce_i & ~(done_s &  grant_r);

endmodule

// File: tb/tb_sopc_mem_bridge.sv
// Directed bench for sopc_mem_bridge: four configurations share the same CPU-side stimulus,
// each memory model returns addr ^ 0xA5A5A5A5.
module tb_sopc_mem_bridge;

  logic        clk;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic        ram_ce;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [3:0]  ram_sel;
  logic [31:0] ram_wdata;

  logic [31:0] rom_data [4];
  logic [31:0] ram_data [4];
  logic        inst_stall [4];
  logic        data_stall [4];
  logic        mem_ce [4];
  logic        mem_we [4];
  logic [31:0] mem_addr [4];
  logic [3:0]  mem_sel [4];
  logic [31:0] mem_wdata [4];

  int n_checks;
  int n_fail;

  // 0: WS=1 priority, 1: WS=1 round-robin, 2: WS=2 priority, 3: WS=0 priority
  for (genvar g = 0; g < 4; g++) begin : g_dut
    sopc_mem_bridge #(
      .ADDR_W       (32),
      .DATA_W       (32),
      .WAIT_STATES  (g == 2 ? 2 : (g == 3 ? 0 : 1)),
      .DATA_PRIORITY(g == 1 ? 0 : 1)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .rom_ce_i    (rom_ce),
      .rom_addr_i  (rom_addr),
      .rom_data_o  (rom_data[g]),
      .inst_stall_o(inst_stall[g]),
      .ram_ce_i    (ram_ce),
      .ram_we_i    (ram_we),
      .ram_addr_i  (ram_addr),
      .ram_sel_i   (ram_sel),
      .ram_data_i  (ram_wdata),
      .ram_data_o  (ram_data[g]),
      .data_stall_o(data_stall[g]),
      .mem_ce_o    (mem_ce[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_sel_o   (mem_sel[g]),
      .mem_data_o  (mem_wdata[g]),
      .mem_data_i  (mem_addr[g] ^ 32'hA5A5A5A5)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; rom_ce = 1'b0; ram_ce = 1'b0; ram_we = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; rom_ce = 1'b0; rom_addr = 32'h0; ram_ce = 1'b0; ram_we = 1'b0;
    ram_addr = 32'h0; ram_sel = 4'h0; ram_wdata = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    check_eq("rst_rom_data", rom_data[0], 32'h0);
    check_eq("rst_ram_data", ram_data[0], 32'h0);
    check_eq("rst_mem_ce", 32'(mem_ce[0]), 32'h0);
    check_eq("rst_mem_addr", mem_addr[0], 32'h0);
    check_eq("rst_inst_stall", 32'(inst_stall[0]), 32'h0);

    // single fetch, WS=1
    do_reset();
    rom_ce = 1'b1; rom_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("fetch_stall", 32'(inst_stall[0]), 32'(c < 2));
      check_eq("fetch_mem_ce", 32'(mem_ce[0]), 32'(c == 1 || c == 2));
      if (c == 2) check_eq("fetch_data", rom_data[0], 32'hA5A5A5B5);
      @(posedge clk); #1;
      if (c == 2) rom_ce = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_eq("fetch_hold", rom_data[0], 32'hA5A5A5B5);
      check_eq("fetch_idle_stall", 32'(inst_stall[0]), 32'h0);
    end

    // tie with data priority
    do_reset();
    rom_ce = 1'b1; rom_addr = 32'h200; ram_ce = 1'b1; ram_we = 1'b0; ram_addr = 32'h100;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("prio_inst_stall", 32'(inst_stall[0]), 32'(c != 5));
      check_eq("prio_data_stall", 32'(data_stall[0]), 32'(c < 2));
      if (c == 2) check_eq("prio_ram_data", ram_data[0], 32'hA5A5A4A5);
      if (c == 5) check_eq("prio_rom_data", rom_data[0], 32'hA5A5A7A5);
      @(posedge clk); #1;
      if (c == 2) ram_ce = 1'b0;
      if (c == 5) rom_ce = 1'b0;
    end

    // round-robin with both ports held
    do_reset();
    rom_ce = 1'b1; rom_addr = 32'h300; ram_ce = 1'b1; ram_addr = 32'h400;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      check_eq("rr_data_stall", 32'(data_stall[1]), 32'(c % 6 != 2));
      check_eq("rr_inst_stall", 32'(inst_stall[1]), 32'(c % 6 != 5));
      if (c % 3 == 1)
        check_eq("rr_grant_addr", mem_addr[1], ((c / 3) % 2 == 0) ? 32'h400 : 32'h300);
      @(posedge clk); #1;
    end
    rom_ce = 1'b0; ram_ce = 1'b0;

    // byte-enabled write, WS=2
    do_reset();
    ram_ce = 1'b1; ram_we = 1'b1; ram_addr = 32'h40; ram_sel = 4'b0011; ram_wdata = 32'hDEADBEEF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("wr_we", 32'(mem_we[2]), 32'(c >= 1 && c <= 3));
      check_eq("wr_sel", 32'(mem_sel[2]), (c >= 1 && c <= 3) ? 32'h3 : 32'h0);
      check_eq("wr_wdata", mem_wdata[2], (c >= 1 && c <= 3) ? 32'hDEADBEEF : 32'h0);
      check_eq("wr_stall", 32'(data_stall[2]), 32'(c < 3));
      if (c == 3) check_eq("wr_no_capture", ram_data[2], 32'h0);
      @(posedge clk); #1;
      if (c == 3) begin ram_ce = 1'b0; ram_we = 1'b0; end
    end

    // reset during a busy fetch
    do_reset();
    rom_ce = 1'b1; rom_addr = 32'h20;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("ab_first_data", rom_data[0], 32'hA5A5A585);
    @(posedge clk); #1;
    rom_addr = 32'h10;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("ab_busy_addr", mem_addr[0], 32'h10);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("ab_mem_ce", 32'(mem_ce[0]), 32'h0);
    check_eq("ab_rom_data", rom_data[0], 32'h0);
    check_eq("ab_stall0", 32'(inst_stall[0]), 32'h1);
    @(negedge clk);
    check_eq("ab_stall1", 32'(inst_stall[0]), 32'h1);
    @(negedge clk);
    check_eq("ab_stall2", 32'(inst_stall[0]), 32'h0);
    check_eq("ab_refetch", rom_data[0], 32'hA5A5A5B5);
    @(posedge clk); #1;
    rom_ce = 1'b0;

    // zero wait states, continuous fetch with address changing every cycle
    do_reset();
    rom_ce = 1'b1; rom_addr = 32'h0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check_eq("ws0_stall", 32'(inst_stall[3]), 32'(c % 2 == 0));
      check_eq("ws0_mem_ce", 32'(mem_ce[3]), 32'(c % 2 == 1));
      if (c % 2 == 1) begin
        check_eq("ws0_addr", mem_addr[3], 32'(16 * (c - 1)));
        check_eq("ws0_data", rom_data[3], 32'(16 * (c - 1)) ^ 32'hA5A5A5A5);
      end
      @(posedge clk); #1;
      rom_addr = 32'(16 * (c + 1));
    end
    rom_ce = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
